psg_write_sched: RTL and testbench

Write scheduler for the TurboSound PSG bank. It captures CPU register-select and data-port writes and queues them in a small FIFO. It issues at most one register write per PSG enable strobe, so the AY cores only see register updates aligned to their clock-enable. It sits between the peripheral port decoder and the PSG instances, in the `clk_peripheral` domain, and is driven by the existing `psg_en` strobe.

---
 rtl/psg_write_sched.sv | 121 ++++++++++++
 tb/tb_psg_write_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/psg_write_sched.sv
// Write scheduler for the TurboSound PSG bank: captures register-select and
// data-port writes, queues them, and issues at most one write per psg_en.
module psg_write_sched #(
  parameter int DEPTH     = 4,
  parameter int NUM_CHIPS = 3
) (
  input  logic                 clk_peripheral,
  input  logic                 reset_n,
  input  logic                 psg_en,
  input  logic                 sel_wr,
  input  logic [7:0]           sel_data,
  input  logic                 dat_wr,
  input  logic [7:0]           dat_data,
  output logic [NUM_CHIPS-1:0] psg_wr,
  output logic [3:0]           psg_reg,
  output logic [7:0]           psg_dat,
  output logic [1:0]           cur_chip,
  output logic                 busy,
  output logic                 overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // Strobe protocol: sel_wr/dat_wr are single-cycle pulses with no backpressure;
  // a dat_wr that finds the queue full and no same-cycle pop is dropped and
  // flagged on overflow. psg_wr is a one-cycle one-hot strobe with psg_reg/psg_dat
  // valid in that same cycle.
  logic [13:0]          r_mem [DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic [1:0]           r_chip;
  logic [3:0]           r_reg;
  logic [NUM_CHIPS-1:0] r_wr;
  logic [3:0]           r_reg_o;
  logic [7:0]           r_dat_o;
  logic                 r_busy;
  logic                 r_ovf;

  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [CW-1:0]        w_count_nxt;
  logic [13:0]          w_head;
  logic [1:0]           w_chip_nxt;
  logic [3:0]           w_reg_nxt;
  logic [NUM_CHIPS-1:0] w_onehot;

  always_comb begin
    w_full      = (r_count == CW'(DEPTH));
    w_pop       = psg_en && (r_count != '0);
    w_push      = dat_wr && (!w_full || w_pop);
    w_drop      = dat_wr && w_full && !w_pop;
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    w_head      = r_mem[r_rptr];
    w_onehot    = NUM_CHIPS'(1) << w_head[13:12];
  end

  // Select decode: 0xFC..0xFF picks the chip (0xFC keeps it), 0x00..0x0F the register.
  always_comb begin
    w_chip_nxt = r_chip;
    w_reg_nxt  = r_reg;
    if (sel_wr) begin
      if (sel_data[7:2] == 6'b111111) begin
        case (sel_data[1:0])
          2'b11:   w_chip_nxt = 2'd0;
          2'b10:   w_chip_nxt = 2'd1;
          2'b01:   w_chip_nxt = 2'd2;
          default: w_chip_nxt = r_chip;
        endcase
      end else if (sel_data[7:4] == 4'b0000) begin
        w_reg_nxt = sel_data[3:0];
      end
    end
  end

  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_chip  <= '0;
      r_reg   <= '0;
      r_wr    <= '0;
      r_reg_o <= '0;
      r_dat_o <= '0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_chip  <= w_chip_nxt;
      r_reg   <= w_reg_nxt;
      r_count <= w_count_nxt;
      r_busy  <= (w_count_nxt != '0);
      r_ovf   <= w_drop;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr  <= r_rptr + AW'(1);
        r_wr    <= w_onehot;
        r_reg_o <= w_head[11:8];
        r_dat_o <= w_head[7:0];
      end else begin
        r_wr    <= '0;
      end
    end
  end

  // Entry captures chip/reg as held before any same-cycle select write.
  always_ff @(posedge clk_peripheral) begin
    if (w_push) r_mem[r_wptr] <= {r_chip, r_reg, dat_data};
  end

  assign psg_wr   = r_wr;
  assign psg_reg  = r_reg_o;
  assign psg_dat  = r_dat_o;
  assign cur_chip = r_chip;
  assign busy     = r_busy;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_psg_write_sched.sv
// Directed, table-driven bench for psg_write_sched: one vector per clock with
// hand-computed expected outputs, plus reset sequences.
module tb_psg_write_sched;

  logic       clk_peripheral = 1'b0;
  logic       reset_n;
  logic       psg_en;
  logic       sel_wr;
  logic [7:0] sel_data;
  logic       dat_wr;
  logic [7:0] dat_data;
  logic [2:0] psg_wr;
  logic [3:0] psg_reg;
  logic [7:0] psg_dat;
  logic [1:0] cur_chip;
  logic       busy;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       sw;
    logic [7:0] sd;
    logic       dw;
    logic [7:0] dd;
    logic       en;
    logic [2:0] wr;
    logic [3:0] rg;
    logic [7:0] dt;
    logic [1:0] ch;
    logic       bz;
    logic       ov;
  } vec_t;

  vec_t vecs[$];

  psg_write_sched #(.DEPTH(4), .NUM_CHIPS(3)) dut (
    .clk_peripheral(clk_peripheral),
    .reset_n       (reset_n),
    .psg_en        (psg_en),
    .sel_wr        (sel_wr),
    .sel_data      (sel_data),
    .dat_wr        (dat_wr),
    .dat_data      (dat_data),
    .psg_wr        (psg_wr),
    .psg_reg       (psg_reg),
    .psg_dat       (psg_dat),
    .cur_chip      (cur_chip),
    .busy          (busy),
    .overflow      (overflow)
  );

  // clock / reset
  always #5 clk_peripheral = ~clk_peripheral;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_peripheral);
    #1;
  endtask

  task automatic idle_inputs();
    psg_en   = 1'b0;
    sel_wr   = 1'b0;
    sel_data = 8'h00;
    dat_wr   = 1'b0;
    dat_data = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".wr"},   32'(psg_wr),   32'h0);
    chk({tag, ".reg"},  32'(psg_reg),  32'h0);
    chk({tag, ".dat"},  32'(psg_dat),  32'h0);
    chk({tag, ".chip"}, 32'(cur_chip), 32'h0);
    chk({tag, ".busy"}, 32'(busy),     32'h0);
    chk({tag, ".ovf"},  32'(overflow), 32'h0);
  endtask

  // vector: sel_wr, sel_data, dat_wr, dat_data, psg_en -> wr, reg, dat, chip, busy, ovf
  function automatic void v(input logic sw, input logic [7:0] sd, input logic dw,
                            input logic [7:0] dd, input logic en, input logic [2:0] wr,
                            input logic [3:0] rg, input logic [7:0] dt, input logic [1:0] ch,
                            input logic bz, input logic ov);
    vec_t t;
    t.sw = sw; t.sd = sd; t.dw = dw; t.dd = dd; t.en = en;
    t.wr = wr; t.rg = rg; t.dt = dt; t.ch = ch; t.bz = bz; t.ov = ov;
    vecs.push_back(t);
  endfunction

  initial begin
    idle_inputs();
    reset_n = 1'b0;

    // reset state while held
    #2;
    check_all_zero("rst_async");
    tick();
    tick();
    check_all_zero("rst_held");
    reset_n = 1'b1;

    // idle with psg_en every 16 cycles
    for (int c = 0; c < 48; c++) begin
      psg_en = (c % 16 == 0);
      tick();
      chk($sformatf("idle%0d.wr", c),   32'(psg_wr),   32'h0);
      chk($sformatf("idle%0d.busy", c), 32'(busy),     32'h0);
      chk($sformatf("idle%0d.chip", c), 32'(cur_chip), 32'h0);
    end
    idle_inputs();

    // basic select + data + issue
    v(1, 8'h07, 0, 8'h00, 0,  3'b000, 4'h0, 8'h00, 2'd0, 0, 0);
    v(0, 8'h00, 1, 8'h3E, 0,  3'b000, 4'h0, 8'h00, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b001, 4'h7, 8'h3E, 2'd0, 0, 0);
    v(0, 8'h00, 0, 8'h00, 0,  3'b000, 4'h7, 8'h3E, 2'd0, 0, 0);
    // chip switching
    v(1, 8'hFE, 0, 8'h00, 0,  3'b000, 4'h7, 8'h3E, 2'd1, 0, 0);
    v(1, 8'h08, 0, 8'h00, 0,  3'b000, 4'h7, 8'h3E, 2'd1, 0, 0);
    v(0, 8'h00, 1, 8'h0F, 0,  3'b000, 4'h7, 8'h3E, 2'd1, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b010, 4'h8, 8'h0F, 2'd1, 0, 0);
    v(1, 8'hFD, 0, 8'h00, 0,  3'b000, 4'h8, 8'h0F, 2'd2, 0, 0);
    v(0, 8'h00, 1, 8'h55, 0,  3'b000, 4'h8, 8'h0F, 2'd2, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b100, 4'h8, 8'h55, 2'd2, 0, 0);
    v(1, 8'hFC, 0, 8'h00, 0,  3'b000, 4'h8, 8'h55, 2'd2, 0, 0);
    // 0x80 is neither a chip nor a register select: chip 2, reg 8 stay
    v(1, 8'h80, 0, 8'h00, 0,  3'b000, 4'h8, 8'h55, 2'd2, 0, 0);
    v(0, 8'h00, 1, 8'h44, 0,  3'b000, 4'h8, 8'h55, 2'd2, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b100, 4'h8, 8'h44, 2'd2, 0, 0);
    v(1, 8'hFF, 0, 8'h00, 0,  3'b000, 4'h8, 8'h44, 2'd0, 0, 0);
    v(1, 8'h03, 0, 8'h00, 0,  3'b000, 4'h8, 8'h44, 2'd0, 0, 0);
    // fill, overflow on the fifth write
    v(0, 8'h00, 1, 8'h01, 0,  3'b000, 4'h8, 8'h44, 2'd0, 1, 0);
    v(0, 8'h00, 1, 8'h02, 0,  3'b000, 4'h8, 8'h44, 2'd0, 1, 0);
    v(0, 8'h00, 1, 8'h03, 0,  3'b000, 4'h8, 8'h44, 2'd0, 1, 0);
    v(0, 8'h00, 1, 8'h04, 0,  3'b000, 4'h8, 8'h44, 2'd0, 1, 0);
    v(0, 8'h00, 1, 8'h05, 0,  3'b000, 4'h8, 8'h44, 2'd0, 1, 1);
    v(0, 8'h00, 0, 8'h00, 0,  3'b000, 4'h8, 8'h44, 2'd0, 1, 0);
    // drain in order
    v(0, 8'h00, 0, 8'h00, 1,  3'b001, 4'h3, 8'h01, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 0,  3'b000, 4'h3, 8'h01, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b001, 4'h3, 8'h02, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b001, 4'h3, 8'h03, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b001, 4'h3, 8'h04, 2'd0, 0, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b000, 4'h3, 8'h04, 2'd0, 0, 0);
    // pointer wrap, then full + simultaneous pop/push
    v(0, 8'h00, 1, 8'h11, 0,  3'b000, 4'h3, 8'h04, 2'd0, 1, 0);
    v(0, 8'h00, 1, 8'h12, 0,  3'b000, 4'h3, 8'h04, 2'd0, 1, 0);
    v(0, 8'h00, 1, 8'h13, 0,  3'b000, 4'h3, 8'h04, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b001, 4'h3, 8'h11, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b001, 4'h3, 8'h12, 2'd0, 1, 0);
    v(0, 8'h00, 1, 8'h14, 0,  3'b000, 4'h3, 8'h12, 2'd0, 1, 0);
    v(0, 8'h00, 1, 8'h15, 0,  3'b000, 4'h3, 8'h12, 2'd0, 1, 0);
    v(0, 8'h00, 1, 8'h16, 0,  3'b000, 4'h3, 8'h12, 2'd0, 1, 0);
    v(0, 8'h00, 1, 8'hAA, 1,  3'b001, 4'h3, 8'h13, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b001, 4'h3, 8'h14, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b001, 4'h3, 8'h15, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b001, 4'h3, 8'h16, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b001, 4'h3, 8'hAA, 2'd0, 0, 0);
    // empty FIFO: push with psg_en is not popped until the next psg_en
    v(0, 8'h00, 1, 8'h77, 1,  3'b000, 4'h3, 8'hAA, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 0,  3'b000, 4'h3, 8'hAA, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b001, 4'h3, 8'h77, 2'd0, 0, 0);
    // same-cycle select uses the old register
    v(1, 8'h02, 1, 8'h99, 0,  3'b000, 4'h3, 8'h77, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b001, 4'h3, 8'h99, 2'd0, 0, 0);
    v(0, 8'h00, 1, 8'h66, 0,  3'b000, 4'h3, 8'h99, 2'd0, 1, 0);
    v(0, 8'h00, 0, 8'h00, 1,  3'b001, 4'h2, 8'h66, 2'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      sel_wr   = vecs[i].sw;
      sel_data = vecs[i].sd;
      dat_wr   = vecs[i].dw;
      dat_data = vecs[i].dd;
      psg_en   = vecs[i].en;
      tick();
      chk($sformatf("v%0d.wr", i),   32'(psg_wr),   32'(vecs[i].wr));
      chk($sformatf("v%0d.reg", i),  32'(psg_reg),  32'(vecs[i].rg));
      chk($sformatf("v%0d.dat", i),  32'(psg_dat),  32'(vecs[i].dt));
      chk($sformatf("v%0d.chip", i), 32'(cur_chip), 32'(vecs[i].ch));
      chk($sformatf("v%0d.busy", i), 32'(busy),     32'(vecs[i].bz));
      chk($sformatf("v%0d.ovf", i),  32'(overflow), 32'(vecs[i].ov));
    end
    idle_inputs();

    // mid-operation reset: 4 queued, one popped (strobe in flight), 3 left
    sel_wr = 1'b1; sel_data = 8'hFE; tick();
    sel_data = 8'h05; tick();
    sel_wr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dat_wr = 1'b1; dat_data = 8'hC0 + 8'(k); tick();
    end
    dat_wr = 1'b0;
    psg_en = 1'b1; tick();
    psg_en = 1'b0;
    chk("mid.wr_before", 32'(psg_wr), 32'h2);
    chk("mid.dat_before", 32'(psg_dat), 32'hC0);
    chk("mid.busy_before", 32'(busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_async");
    tick();
    check_all_zero("mid_held");
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      psg_en = (c % 8 == 0);
      tick();
      chk($sformatf("post%0d.wr", c),   32'(psg_wr), 32'h0);
      chk($sformatf("post%0d.busy", c), 32'(busy),   32'h0);
    end
    psg_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
